button_bank_debouncer: RTL

Parametrised multi-channel push-button conditioner for the kitchen-timer front panel. It takes N raw, bouncy, asynchronous button pins. For each channel it produces a synchronised, debounced level and one-cycle press/release strobes. It also produces long-press and optional auto-repeat strobes. It sits between the board pins and the timer control FSM, replacing per-button single-channel debouncers.

---
 rtl/kt_button_pkg.sv | 19 +
 rtl/button_channel.sv | 142 ++++++++++++++
 rtl/button_bank_debouncer.sv | 53 +++++
 3 files changed

// File: rtl/kt_button_pkg.sv
// ============================================================================
// Module      : kt_button_pkg
// Description : Shared clock and timing defaults for the kitchen-timer buttons.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kt_button_pkg;

    localparam int unsigned CLK_HZ            = 50_000_000;

    // 2^16 cycles is roughly 1.3 ms of required stability at CLK_HZ.
    localparam int unsigned DEB_CYCLES_DEF    = 65536;
    localparam int unsigned HOLD_CYCLES_DEF   = CLK_HZ;
    localparam int unsigned REPEAT_CYCLES_DEF = CLK_HZ / 5;

endpackage

`default_nettype wire

// File: rtl/button_channel.sv
// ============================================================================
// Module      : button_channel
// Description : One button: synchroniser, debounce, long-press and repeat.
//               Auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_channel
    import kt_button_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic pb_state,
    output logic pb_down,
    output logic pb_up,
    output logic pb_long,
    output logic pb_repeat
);

    localparam int unsigned          c_deb_w     = $clog2(DEB_CYCLES + 1);
    localparam int unsigned          c_hold_w    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_deb_w-1:0]   c_deb_last  = c_deb_w'(DEB_CYCLES - 1);
    localparam logic [c_hold_w-1:0]  c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_hold_w-1:0]  c_hold_max  = c_hold_w'(HOLD_CYCLES);

    logic                w_pin_norm;
    logic                r_sync0;
    logic                r_sync1;
    logic [c_deb_w-1:0]  r_deb_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_state;
    logic                r_down;
    logic                r_up;
    logic                r_long;
    logic                w_mismatch;
    logic                w_accept;
    logic                w_rise;
    logic                w_fall;
    logic                w_long_hit;

    assign w_pin_norm = ACTIVE_LOW ? ~pb_in : pb_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= w_pin_norm;
            r_sync1 <= r_sync0;
        end
    end

    // Any cycle agreeing with the accepted level restarts the stability count.
    assign w_mismatch = (r_sync1 != r_state);
    assign w_accept   = w_mismatch && (r_deb_cnt == c_deb_last);
    assign w_rise     = w_accept && !r_state;
    assign w_fall     = w_accept &&  r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_cnt <= '0;
            r_state   <= 1'b0;
            r_down    <= 1'b0;
            r_up      <= 1'b0;
        end else begin
            if (!w_mismatch || w_accept) begin
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
            end
            if (w_accept) begin
                r_state <= ~r_state;
            end
            r_down <= w_rise;
            r_up   <= w_fall;
        end
    end

    // Saturating at HOLD_CYCLES guarantees a single long strobe per press.
    assign w_long_hit = r_state && (r_hold_cnt == c_hold_last) && !w_fall;

    always_ff @(posedge clk) begin
        if (rst || !r_state || w_fall) begin
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            if (r_hold_cnt != c_hold_max) begin
                r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
            end
            r_long <= w_long_hit;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned         c_rpt_w    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_rpt_w-1:0]  c_rpt_last = c_rpt_w'(REPEAT_CYCLES - 1);

    logic               r_long_seen;
    logic [c_rpt_w-1:0] r_rpt_cnt;
    logic               r_repeat;
    logic               w_rpt_hit;

    assign w_rpt_hit = r_long_seen && r_state && (r_rpt_cnt == c_rpt_last) && !w_fall;

    always_ff @(posedge clk) begin
        if (rst || !r_state || w_fall) begin
            r_long_seen <= 1'b0;
            r_rpt_cnt   <= '0;
            r_repeat    <= 1'b0;
        end else begin
            if (w_long_hit) begin
                r_long_seen <= 1'b1;
            end
            if (!r_long_seen || w_rpt_hit) begin
                r_rpt_cnt <= '0;
            end else begin
                r_rpt_cnt <= r_rpt_cnt + c_rpt_w'(1);
            end
            r_repeat <= w_rpt_hit;
        end
    end

    assign pb_repeat = r_repeat;
`else
    assign pb_repeat = 1'b0;
`endif

    assign pb_state = r_state;
    assign pb_down  = r_down;
    assign pb_up    = r_up;
    assign pb_long  = r_long;

endmodule

`default_nettype wire

// File: rtl/button_bank_debouncer.sv
// ============================================================================
// Module      : button_bank_debouncer
// Description : N-channel push-button conditioner built from button_channel.
//               Auto-repeat is enabled by defining BTN_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_bank_debouncer
    import kt_button_pkg::*;
#(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb_in,
    output logic [N_BTN-1:0] pb_state,
    output logic [N_BTN-1:0] pb_down,
    output logic [N_BTN-1:0] pb_up,
    output logic [N_BTN-1:0] pb_long,
    output logic [N_BTN-1:0] pb_repeat,
    output logic             any_down
);

    generate
        for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
            button_channel #(
                .DEB_CYCLES    (DEB_CYCLES),
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES),
                .ACTIVE_LOW    (ACTIVE_LOW)
            ) u_channel (
                .clk       (clk),
                .rst       (rst),
                .pb_in     (pb_in[i]),
                .pb_state  (pb_state[i]),
                .pb_down   (pb_down[i]),
                .pb_up     (pb_up[i]),
                .pb_long   (pb_long[i]),
                .pb_repeat (pb_repeat[i])
            );
        end
    endgenerate

    assign any_down = |pb_down;

endmodule

`default_nettype wire
